// File: rtl/input_judge_if.sv
// Draw handshake between the input judge and the white-square draw stage,
// plus the line-6 clear strobe and the offset captured for the draw.
interface input_judge_if;
    logic       correct_go;
    logic       correct_done;
    logic [5:0] offset;
    logic       clear_line6;

    modport master (
        output correct_go,
        output offset,
        output clear_line6,
        input  correct_done
    );

    modport slave (
        input  correct_go,
        input  offset,
        input  clear_line6,
        output correct_done
    );
endinterface

// File: rtl/input_judge.sv
// Judges player key presses against the bottom-row tile, drives the draw
// handshake for correct hits, keeps the saturating score and sticky error flags.
module input_judge #(
    parameter int SCORE_W      = 10,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [3:0]         key_n,
    input  logic               enable,
    input  logic [2:0]         line_6,
    input  logic [5:0]         offset_in,
    input_judge_if.master      draw,
    output logic [SCORE_W-1:0] score,
    output logic               game_over,
    output logic               draw_err,
    output logic               busy
);

    localparam int CNT_W = (DONE_TIMEOUT > 2) ? $clog2(DONE_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        JUDGE,
        GO,
        WAIT_DONE,
        CLEAR,
        OVER
    } state_t;

    state_t state, state_nxt;

    logic [3:0]       sync_p0;
    logic [3:0]       sync_p1;
    logic [3:0]       key_s;
    logic [3:0]       key_s_d;
    logic [3:0]       press;
    logic [3:0]       kp;
    logic [2:0]       line_l;
    logic [5:0]       offset_l;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             take;
    logic             go_c;
    logic             clear_c;
    logic             busy_c;
    logic             over_c;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    // One-hot key matching the tile column; multi-key or empty row never matches.
    function automatic logic is_hit(input logic [3:0] keys, input logic [2:0] line);
        return line[2] && (keys == (4'b0001 << line[1:0]));
    endfunction

    // Synchroniser stages and edge detector; reset state is "all keys released".
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
            key_s_d <= '0;
        end else begin
            sync_p0 <= key_n;
            sync_p1 <= sync_p0;
            key_s_d <= key_s;
        end
    end

    assign key_s   = ~sync_p1;
    assign press   = key_s & ~key_s_d;
    assign take    = (state == IDLE) && enable && (|press);
    assign tmo_hit = (tmo_cnt == CNT_W'(DONE_TIMEOUT - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        go_c      = 1'b0;
        clear_c   = 1'b0;
        busy_c    = 1'b1;
        over_c    = 1'b0;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (take) begin
                    state_nxt = JUDGE;
                end
            end
            JUDGE: begin
                state_nxt = is_hit(kp, line_l) ? GO : OVER;
            end
            GO: begin
                go_c      = 1'b1;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (draw.correct_done || tmo_hit) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                clear_c   = 1'b1;
                state_nxt = IDLE;
            end
            OVER: begin
                over_c = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Judge capture: the press pattern, the row and the scroll offset are frozen
    // together so the draw sees a consistent snapshot.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            kp       <= '0;
            line_l   <= '0;
            offset_l <= '0;
        end else if (take) begin
            kp       <= press;
            line_l   <= line_6;
            offset_l <= offset_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt  <= '0;
            draw_err <= 1'b0;
        end else if (state == GO) begin
            tmo_cnt <= '0;
        end else if (state == WAIT_DONE) begin
            if (!draw.correct_done && tmo_hit) begin
                draw_err <= 1'b1;
            end else begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            score <= '0;
        end else if (state == CLEAR) begin
            score <= sat_inc(score);
        end
    end

    assign draw.correct_go  = go_c;
    assign draw.clear_line6 = clear_c;
    assign draw.offset      = offset_l;
    assign busy             = busy_c;
    assign game_over        = over_c;

endmodule

// File: tb/tb_input_judge.sv
// Directed bench for input_judge: one DUT with default parameters and one with
// SCORE_W=3, DONE_TIMEOUT=16, both sharing the same stimulus.
module tb_input_judge;

    logic       clock;
    logic       resetn;
    logic [3:0] key_n;
    logic       enable;
    logic [2:0] line_6;
    logic [5:0] offset_in;
    logic       done;

    logic [9:0] a_score;
    logic       a_over, a_err, a_busy;
    logic [2:0] b_score;
    logic       b_over, b_err, b_busy;

    int tests;
    int fails;

    input_judge_if ifa ();
    input_judge_if ifb ();

    assign ifa.correct_done = done;
    assign ifb.correct_done = done;

    input_judge dut_a (
        .clock(clock), .resetn(resetn), .key_n(key_n), .enable(enable),
        .line_6(line_6), .offset_in(offset_in), .draw(ifa.master),
        .score(a_score), .game_over(a_over), .draw_err(a_err), .busy(a_busy)
    );

    input_judge #(.SCORE_W(3), .DONE_TIMEOUT(16)) dut_b (
        .clock(clock), .resetn(resetn), .key_n(key_n), .enable(enable),
        .line_6(line_6), .offset_in(offset_in), .draw(ifb.master),
        .score(b_score), .game_over(b_over), .draw_err(b_err), .busy(b_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        key_n     = 4'hF;
        enable    = 1'b1;
        line_6    = 3'b000;
        offset_in = 6'h00;
        done      = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        tests++;
        if ({ifa.correct_go, ifa.clear_line6, a_over, a_err, a_busy} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags_a: got %b expected 00000",
                     {ifa.correct_go, ifa.clear_line6, a_over, a_err, a_busy});
        end
        tests++;
        if (a_score !== 10'd0 || ifa.offset !== 6'd0) begin
            fails++;
            $display("FAIL reset_data_a: score %0d offset %0h expected 0 0", a_score, ifa.offset);
        end
        tests++;
        if ({ifb.correct_go, ifb.clear_line6, b_over, b_err, b_busy, b_score} !== 8'b0) begin
            fails++;
            $display("FAIL reset_b: got %b expected 0",
                     {ifb.correct_go, ifb.clear_line6, b_over, b_err, b_busy, b_score});
        end
        do_reset();
    endtask

    task automatic test_hit();
        do_reset();
        line_6    = 3'b110;
        offset_in = 6'h2A;
        key_n     = 4'b1011;
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            tests++;
            if (ifa.correct_go !== 1'b0) begin
                fails++;
                $display("FAIL hit_go_early[%0d]: got %b expected 0", i, ifa.correct_go);
            end
        end
        tick(1);
        tests++;
        if (ifa.correct_go !== 1'b1 || ifa.offset !== 6'h2A) begin
            fails++;
            $display("FAIL hit_go: go %b offset %0h expected 1 2a", ifa.correct_go, ifa.offset);
        end
        offset_in = 6'h11;
        tick(1);
        tests++;
        if (ifa.correct_go !== 1'b0 || a_busy !== 1'b1 || ifa.offset !== 6'h2A) begin
            fails++;
            $display("FAIL hit_wait: go %b busy %b offset %0h expected 0 1 2a",
                     ifa.correct_go, a_busy, ifa.offset);
        end
        tick(19);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        tests++;
        if (ifa.clear_line6 !== 1'b1 || a_score !== 10'd0) begin
            fails++;
            $display("FAIL hit_clear: clear %b score %0d expected 1 0", ifa.clear_line6, a_score);
        end
        tick(1);
        tests++;
        if (ifa.clear_line6 !== 1'b0 || a_score !== 10'd1 || a_busy !== 1'b0 || a_err !== 1'b0) begin
            fails++;
            $display("FAIL hit_done: clear %b score %0d busy %b err %b expected 0 1 0 0",
                     ifa.clear_line6, a_score, a_busy, a_err);
        end
        key_n = 4'hF;
        tick(3);
    endtask

    task automatic test_wrong();
        do_reset();
        line_6 = 3'b101;
        key_n  = 4'b0111;
        tick(3);
        tests++;
        if (a_over !== 1'b0) begin
            fails++;
            $display("FAIL wrong_early: game_over %b expected 0", a_over);
        end
        tick(1);
        tests++;
        if (a_over !== 1'b1 || ifa.correct_go !== 1'b0) begin
            fails++;
            $display("FAIL wrong_over: over %b go %b expected 1 0", a_over, ifa.correct_go);
        end
        key_n = 4'hF;
        tick(3);
        key_n = 4'b1101;
        tick(6);
        tests++;
        if (a_over !== 1'b1 || a_score !== 10'd0 || ifa.correct_go !== 1'b0) begin
            fails++;
            $display("FAIL wrong_sticky: over %b score %0d go %b expected 1 0 0",
                     a_over, a_score, ifa.correct_go);
        end
    endtask

    task automatic test_multi_and_empty();
        do_reset();
        line_6 = 3'b100;
        key_n  = 4'b1100;
        tick(4);
        tests++;
        if (a_over !== 1'b1) begin
            fails++;
            $display("FAIL multi_key: game_over %b expected 1", a_over);
        end
        do_reset();
        line_6 = 3'b001;
        key_n  = 4'b1101;
        tick(4);
        tests++;
        if (a_over !== 1'b1 || ifa.correct_go !== 1'b0) begin
            fails++;
            $display("FAIL empty_row: over %b go %b expected 1 0", a_over, ifa.correct_go);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        line_6 = 3'b111;
        key_n  = 4'b0111;
        tick(4);
        tests++;
        if (ifb.correct_go !== 1'b1) begin
            fails++;
            $display("FAIL tmo_go: got %b expected 1", ifb.correct_go);
        end
        tick(16);
        tests++;
        if (ifb.clear_line6 !== 1'b0 || b_err !== 1'b0 || b_busy !== 1'b1) begin
            fails++;
            $display("FAIL tmo_wait16: clear %b err %b busy %b expected 0 0 1",
                     ifb.clear_line6, b_err, b_busy);
        end
        tick(1);
        tests++;
        if (ifb.clear_line6 !== 1'b1 || b_err !== 1'b1) begin
            fails++;
            $display("FAIL tmo_clear: clear %b err %b expected 1 1", ifb.clear_line6, b_err);
        end
        tick(1);
        tests++;
        if (b_score !== 3'd1 || b_busy !== 1'b0 || b_err !== 1'b1) begin
            fails++;
            $display("FAIL tmo_after: score %0d busy %b err %b expected 1 0 1", b_score, b_busy, b_err);
        end
        key_n = 4'hF;
        tick(3);
    endtask

    task automatic test_back_to_back();
        do_reset();
        line_6 = 3'b110;
        key_n  = 4'b1011;
        tick(5);
        key_n = 4'b1101;
        tick(3);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        tick(1);
        tests++;
        if (a_score !== 10'd1 || a_busy !== 1'b0) begin
            fails++;
            $display("FAIL held_first: score %0d busy %b expected 1 0", a_score, a_busy);
        end
        line_6 = 3'b101;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            tests++;
            if (ifa.correct_go !== 1'b0 || a_busy !== 1'b0) begin
                fails++;
                $display("FAIL held_retrigger[%0d]: go %b busy %b expected 0 0", i, ifa.correct_go, a_busy);
            end
        end
        key_n = 4'hF;
        tick(3);
        key_n = 4'b1101;
        tick(4);
        tests++;
        if (ifa.correct_go !== 1'b1) begin
            fails++;
            $display("FAIL repress_go: got %b expected 1", ifa.correct_go);
        end
        key_n = 4'hF;
        tick(1);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        tick(1);
        tests++;
        if (a_score !== 10'd2 || a_over !== 1'b0) begin
            fails++;
            $display("FAIL repress_score: score %0d over %b expected 2 0", a_score, a_over);
        end
        tick(2);
    endtask

    task automatic test_saturate();
        int exp;
        do_reset();
        line_6 = 3'b100;
        for (int i = 0; i < 8; i++) begin
            key_n = 4'b1110;
            tick(5);
            done = 1'b1;
            tick(1);
            done = 1'b0;
            tick(1);
            exp = (i + 1 > 7) ? 7 : i + 1;
            tests++;
            if (b_score !== 3'(exp)) begin
                fails++;
                $display("FAIL sat_score[%0d]: got %0d expected %0d", i, b_score, exp);
            end
            key_n = 4'hF;
            tick(3);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        line_6 = 3'b110;
        key_n  = 4'b1011;
        tick(5);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        tick(1);
        key_n = 4'hF;
        tick(3);
        key_n = 4'b1011;
        tick(6);
        tests++;
        if (a_busy !== 1'b1 || a_score !== 10'd1) begin
            fails++;
            $display("FAIL mid_pre: busy %b score %0d expected 1 1", a_busy, a_score);
        end
        resetn = 1'b0;
        #1;
        tests++;
        if ({ifa.correct_go, ifa.clear_line6, a_over, a_err, a_busy} !== 5'b0 ||
            a_score !== 10'd0 || ifa.offset !== 6'd0) begin
            fails++;
            $display("FAIL mid_reset: flags %b score %0d offset %0h expected 00000 0 0",
                     {ifa.correct_go, ifa.clear_line6, a_over, a_err, a_busy}, a_score, ifa.offset);
        end
        key_n = 4'hF;
        tick(1);
        resetn = 1'b1;
        done   = 1'b1;
        tick(1);
        done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            tests++;
            if (ifa.clear_line6 !== 1'b0 || a_score !== 10'd0 || a_busy !== 1'b0) begin
                fails++;
                $display("FAIL mid_after[%0d]: clear %b score %0d busy %b expected 0 0 0",
                         i, ifa.clear_line6, a_score, a_busy);
            end
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        resetn    = 1'b0;
        key_n     = 4'hF;
        enable    = 1'b0;
        line_6    = 3'b000;
        offset_in = 6'h00;
        done      = 1'b0;
        tick(1);
        test_reset();
        test_hit();
        test_wrong();
        test_multi_and_empty();
        test_timeout();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
